mem_port_arbiter: RTL and testbench

//   Shares one single-port instruction/data memory between the RV32I core's fetch port and its load/store port.

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the load/store port.
// One transaction in flight; data has priority, bounded by a fetch starvation guard and a timeout.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam int unsigned TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [STREAK_W-1:0] StreakMax = STREAK_W'(MAX_DATA_STREAK);
  localparam logic [TMO_W-1:0]    TmoLast   = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StWait = 1'b1;

  localparam logic OwnIf = 1'b0;
  localparam logic OwnD  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic                owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;

  logic                resp_valid;
  logic                resp_err;
  logic [DATA_W-1:0]   resp_data;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    tmo_d      = tmo_q;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    if_rvalid  = 1'b0;
    if_rdata   = '0;
    if_err     = 1'b0;
    d_rvalid   = 1'b0;
    d_rdata    = '0;
    d_err      = 1'b0;

    // Everything is forced quiet while reset is held low.
    if (reset) begin
      case (state_q)
        StIdle: begin
          if (d_req && (!if_req || (streak_q != StreakMax))) begin
            d_gnt     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
            state_d   = StWait;
            owner_d   = OwnD;
            tmo_d     = '0;
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q != StreakMax) begin
              streak_d = streak_q + 1'b1;
            end
          end else if (if_req) begin
            if_gnt   = 1'b1;
            mem_req  = 1'b1;
            mem_addr = if_addr;
            mem_be   = '1;
            state_d  = StWait;
            owner_d  = OwnIf;
            tmo_d    = '0;
            streak_d = '0;
          end
        end
        StWait: begin
          if (mem_rvalid) begin
            resp_valid = 1'b1;
            resp_data  = mem_rdata;
            state_d    = StIdle;
          end else if (tmo_q == TmoLast) begin
            resp_valid = 1'b1;
            resp_err   = 1'b1;
            state_d    = StIdle;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
          if (owner_q == OwnD) begin
            d_rvalid = resp_valid;
            d_rdata  = resp_data;
            d_err    = resp_err;
          end else begin
            if_rvalid = resp_valid;
            if_rdata  = resp_data;
            if_err    = resp_err;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      owner_q  <= OwnIf;
      streak_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a transaction-level model predicts every output
// each cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int MaxStreak = 4;
  localparam int Tmo       = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .MAX_DATA_STREAK(MaxStreak),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Transaction-level model: is a request in flight, whose, how long since its grant.
  bit busy = 1'b0;
  bit own_d = 1'b0;
  int waited = 0;
  int streak = 0;
  bit e_ig = 1'b0;
  bit e_dg = 1'b0;

  // Memory model: countdown to the single pending response, 0 means none.
  int          mem_cd = 0;
  int          lat = 1;
  logic [31:0] mem_word = '0;

  logic        a_ig, a_dg, a_irv, a_drv, a_ie, a_de, a_mreq, a_mwe;
  logic [31:0] a_ird, a_drd, a_maddr, a_mwd;
  logic [3:0]  a_mbe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic        x_irv, x_drv, x_ie, x_de, x_mreq, x_mwe;
    logic [31:0] x_ird, x_drd, x_maddr, x_mwd;
    logic [3:0]  x_mbe;
    bit          done;
    mem_rvalid = (mem_cd == 1);
    mem_rdata  = mem_rvalid ? mem_word : $urandom();
    if (mem_cd > 0) mem_cd--;
    #4;
    {x_irv, x_drv, x_ie, x_de, x_mreq, x_mwe} = '0;
    {x_ird, x_drd, x_maddr, x_mwd} = '0;
    x_mbe = '0;
    e_ig = 1'b0;
    e_dg = 1'b0;
    done = 1'b0;
    if (reset) begin
      if (!busy) begin
        e_dg = d_req && (!if_req || streak < MaxStreak);
        e_ig = if_req && !e_dg;
        if (e_dg) begin
          x_mreq = 1'b1; x_mwe = d_we; x_maddr = d_addr; x_mwd = d_wdata; x_mbe = d_be;
        end
        if (e_ig) begin
          x_mreq = 1'b1; x_maddr = if_addr; x_mbe = 4'hf;
        end
      end else begin
        waited++;
        if (mem_rvalid || waited == Tmo) begin
          done = 1'b1;
          if (own_d) begin
            x_drv = 1'b1; x_de = !mem_rvalid; x_drd = mem_rvalid ? mem_rdata : 32'h0;
          end else begin
            x_irv = 1'b1; x_ie = !mem_rvalid; x_ird = mem_rvalid ? mem_rdata : 32'h0;
          end
        end
      end
    end
    a_ig = if_gnt; a_dg = d_gnt; a_irv = if_rvalid; a_drv = d_rvalid;
    a_ie = if_err; a_de = d_err; a_ird = if_rdata; a_drd = d_rdata;
    a_mreq = mem_req; a_mwe = mem_we; a_maddr = mem_addr; a_mwd = mem_wdata; a_mbe = mem_be;
    chk("if_gnt", 32'(a_ig), 32'(e_ig));
    chk("d_gnt", 32'(a_dg), 32'(e_dg));
    chk("mem_req", 32'(a_mreq), 32'(x_mreq));
    chk("mem_we", 32'(a_mwe), 32'(x_mwe));
    chk("mem_addr", a_maddr, x_maddr);
    chk("mem_wdata", a_mwd, x_mwd);
    chk("mem_be", 32'(a_mbe), 32'(x_mbe));
    chk("if_rvalid", 32'(a_irv), 32'(x_irv));
    chk("if_err", 32'(a_ie), 32'(x_ie));
    chk("if_rdata", a_ird, x_ird);
    chk("d_rvalid", 32'(a_drv), 32'(x_drv));
    chk("d_err", 32'(a_de), 32'(x_de));
    chk("d_rdata", a_drd, x_drd);
    if (!reset) begin
      busy = 1'b0;
      streak = 0;
    end else if (e_dg || e_ig) begin
      busy   = 1'b1;
      own_d  = e_dg;
      waited = 0;
      mem_cd = lat;
      if (e_ig || !if_req) streak = 0;
      else if (streak < MaxStreak) streak++;
    end else if (done) begin
      busy = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] seq;
    int         ng;
    int         last_g;
    int         r;

    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset: requests pending but everything stays quiet.
    if_req = 1'b1; d_req = 1'b1;
    tick();
    chk("rst_mem_req", 32'(a_mreq), 32'h0);
    chk("rst_gnts", 32'({a_ig, a_dg}), 32'h0);
    if_req = 1'b0; d_req = 1'b0; reset = 1'b1;
    tick();

    // Fetch with latency 1.
    if_req = 1'b1; if_addr = 32'h0000_0010; lat = 1; mem_word = 32'h0010_0093;
    tick();
    chk("t1_gnt", 32'(a_ig), 32'h1);
    chk("t1_addr", a_maddr, 32'h0000_0010);
    chk("t1_be", 32'(a_mbe), 32'hf);
    if_req = 1'b0;
    tick();
    chk("t1_rvalid", 32'(a_irv), 32'h1);
    chk("t1_rdata", a_ird, 32'h0010_0093);
    chk("t1_err", 32'(a_ie), 32'h0);

    // Store, latency 2.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
    lat = 2;
    tick();
    chk("t3_gnt", 32'(a_dg), 32'h1);
    chk("t3_we", 32'(a_mwe), 32'h1);
    chk("t3_be", 32'(a_mbe), 32'h3);
    d_req = 1'b0;
    tick();
    tick();
    chk("t3_ack", 32'(a_drv), 32'h1);
    chk("t3_if_quiet", 32'(a_irv), 32'h0);

    // Both always requesting: starvation guard lets IF in after four data grants.
    d_we = 1'b0; d_addr = 32'h0000_0200; if_req = 1'b1; d_req = 1'b1; lat = 1;
    seq = '0; ng = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (a_dg) begin seq = {seq[8:0], 1'b1}; ng++; end
      if (a_ig) begin seq = {seq[8:0], 1'b0}; ng++; end
    end
    chk("t2_order", 32'(seq), 32'(10'b1111011110));
    chk("t2_count", 32'(ng), 32'd10);

    // Memory never answers: error eight cycles after the grant, late response ignored.
    if_req = 1'b0; d_req = 1'b1; lat = 0;
    tick();
    chk("t4_gnt", 32'(a_dg), 32'h1);
    d_req = 1'b0;
    ng = 0;
    repeat (7) begin
      tick();
      if (a_drv || a_irv) ng++;
    end
    chk("t4_early", 32'(ng), 32'h0);
    tick();
    chk("t4_rvalid", 32'(a_drv), 32'h1);
    chk("t4_err", 32'(a_de), 32'h1);
    chk("t4_rdata", a_drd, 32'h0);
    mem_cd = 1; mem_word = 32'h1234_5678;
    tick();
    chk("t4_late", 32'({a_drv, a_irv}), 32'h0);

    // Reset in the middle of a latency-3 fetch.
    if_req = 1'b1; if_addr = 32'h0000_0040; lat = 3;
    tick();
    if_req = 1'b0;
    tick();
    reset = 1'b0; if_req = 1'b1; d_req = 1'b1;
    tick();
    chk("t5_rst_req", 32'(a_mreq), 32'h0);
    chk("t5_rst_gnt", 32'({a_ig, a_dg}), 32'h0);
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0;
    tick();
    chk("t5_stale", 32'({a_irv, a_drv}), 32'h0);
    if_req = 1'b1;
    tick();
    chk("t5_regnt", 32'(a_ig), 32'h1);
    if_req = 1'b0;
    repeat (4) tick();

    // Latency 5 back-to-back loads: grants six cycles apart.
    lat = 5; d_req = 1'b1; d_we = 1'b0; last_g = -1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (a_dg) begin
        if (last_g >= 0) chk("t6_spacing", 32'(cyc - 1 - last_g), 32'd6);
        last_g = cyc - 1;
      end
    end

    // Random traffic, latencies and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if (e_ig) if_req = 1'b0;
      if (e_dg) d_req = 1'b0;
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = $urandom() & 32'hffff_fffc;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom();
        d_wdata = $urandom(); d_be = 4'($urandom_range(0, 15));
      end
      r = $urandom_range(0, 19);
      lat = (r < 16) ? 1 + (r % 6) : ((r < 18) ? 0 : 12);
      mem_word = $urandom();
      reset = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
